// File: rtl/im_fetch_unit.sv
// Instruction fetch front-end: walks a PC through the IM stall handshake and
// queues {pc, instr} pairs in a small prefetch FIFO for the core.
module im_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_en,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        IM_enable,
    output logic [15:0] IM_address,
    input  logic        IM_stall,
    input  logic [31:0] IM_out,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_KILL} state_t;

    state_t                 state_q;
    logic [31:0]            pc_q;
    logic [15:0]            addr_q;
    logic                   en_q;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [PW-1:0]          wr_q, rd_q;
    logic [DEPTH-1:0][31:0] fifo_pc_q;
    logic [DEPTH-1:0][31:0] fifo_ins_q;

    logic        complete, push, pop, space;
    logic [31:0] rpc, pc_inc, kill_pc;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        complete = en_q & ~IM_stall;
        pop      = (cnt_q != '0) & inst_ready;
        push     = (state_q == S_FETCH) & complete & ~redirect_valid;
        space    = (cnt_q < DEPTH_C);
        rpc      = redirect_pc & ~32'd3;
        pc_inc   = pc_q + 32'd4;
        kill_pc  = redirect_valid ? rpc : pc_q;
        // Redirect flushes everything, including an entry popped this cycle.
        cnt_d = cnt_q;
        if (redirect_valid)
            cnt_d = '0;
        else if (push && !pop)
            cnt_d = cnt_q + 1'b1;
        else if (pop && !push)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC[17:2];
            en_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (redirect_valid) begin
                        pc_q <= rpc;
                    end else if (fetch_en && space) begin
                        state_q <= S_FETCH;
                        en_q    <= 1'b1;
                        addr_q  <= pc_q[17:2];
                    end
                end
                S_FETCH: begin
                    if (complete) begin
                        if (redirect_valid) begin
                            pc_q <= rpc;
                            if (fetch_en) begin
                                addr_q <= rpc[17:2];
                            end else begin
                                state_q <= S_IDLE;
                                en_q    <= 1'b0;
                            end
                        end else begin
                            pc_q <= pc_inc;
                            if (fetch_en && (cnt_d < DEPTH_C)) begin
                                addr_q <= pc_inc[17:2];
                            end else begin
                                state_q <= S_IDLE;
                                en_q    <= 1'b0;
                            end
                        end
                    end else if (redirect_valid) begin
                        // IM cannot be abandoned mid-access: keep the old
                        // address up until it completes, then drop the word.
                        pc_q    <= rpc;
                        state_q <= S_KILL;
                    end
                end
                S_KILL: begin
                    pc_q <= kill_pc;
                    if (complete) begin
                        if (fetch_en) begin
                            state_q <= S_FETCH;
                            addr_q  <= kill_pc[17:2];
                        end else begin
                            state_q <= S_IDLE;
                            en_q    <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    en_q    <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            fifo_pc_q  <= '0;
            fifo_ins_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (redirect_valid) begin
                wr_q <= '0;
                rd_q <= '0;
            end else begin
                if (push) begin
                    fifo_pc_q[wr_q]  <= pc_q;
                    fifo_ins_q[wr_q] <= IM_out;
                    wr_q             <= ptr_inc(wr_q);
                end
                if (pop)
                    rd_q <= ptr_inc(rd_q);
            end
        end
    end

    assign IM_enable  = en_q;
    assign IM_address = addr_q;
    assign inst_valid = (cnt_q != '0);
    assign inst_data  = inst_valid ? fifo_ins_q[rd_q] : 32'd0;
    assign inst_pc    = inst_valid ? fifo_pc_q[rd_q]  : 32'd0;

endmodule

// File: tb/tb_im_fetch_unit.sv
// Directed bench for im_fetch_unit with a 3-cycle IM model whose word at
// index a is {16'hA000, a}.
module tb_im_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_en, redirect_valid, inst_ready;
    logic [31:0] redirect_pc;
    logic        IM_enable, IM_stall, inst_valid;
    logic [15:0] IM_address;
    logic [31:0] IM_out, inst_data, inst_pc;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    im_fetch_unit #(.RESET_PC(32'h0), .DEPTH(2)) dut (
        .clk(clk), .rst(rst), .fetch_en(fetch_en),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .IM_enable(IM_enable), .IM_address(IM_address),
        .IM_stall(IM_stall), .IM_out(IM_out),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_data(inst_data), .inst_pc(inst_pc)
    );

    // IM: stall, stall, ready for every access
    logic [1:0] wcnt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)            wcnt <= 2'd0;
        else if (IM_enable) wcnt <= (wcnt == 2'd2) ? 2'd0 : wcnt + 2'd1;
    end
    assign IM_stall = IM_enable && (wcnt != 2'd2);
    assign IM_out   = {16'hA000, IM_address};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; fetch_en = 1'b0; inst_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 32'h0;
        step(2);
        rst = 1'b0;
    endtask

    initial begin
        logic [15:0] maxa;

        do_reset();
        rst = 1'b1;
        #1;
        chk("rst_en", {31'd0, IM_enable}, 32'd0);
        chk("rst_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst_data", inst_data, 32'd0);
        chk("rst_pc", inst_pc, 32'd0);

        // T1: sequential stream, one instruction every 3 cycles
        do_reset();
        fetch_en = 1'b1; inst_ready = 1'b1;
        for (int n = 0; n < 4; n++) begin
            step(n == 0 ? 1 : 2);
            chk("t1_en", {31'd0, IM_enable}, 32'd1);
            chk("t1_addr", {16'd0, IM_address}, n);
            if (n > 0) begin
                chk("t1_valid", {31'd0, inst_valid}, 32'd1);
                chk("t1_pc", inst_pc, 32'(4 * (n - 1)));
                chk("t1_data", inst_data, 32'hA000_0000 + 32'(n - 1));
            end
            step(1);
            chk("t1_gap", {31'd0, inst_valid}, 32'd0);
        end

        // T2: back-pressure fills the FIFO and stops issue
        do_reset();
        fetch_en = 1'b1;
        maxa = 16'd0;
        for (int i = 0; i < 16; i++) begin
            step(1);
            if (IM_enable && IM_address > maxa) maxa = IM_address;
        end
        chk("t2_maxaddr", {16'd0, maxa}, 32'd1);
        chk("t2_en_idle", {31'd0, IM_enable}, 32'd0);
        chk("t2_head0", inst_pc, 32'h0);
        inst_ready = 1'b1;
        step(1);
        chk("t2_head4", inst_pc, 32'h4);
        chk("t2_en_still", {31'd0, IM_enable}, 32'd0);
        step(1);
        chk("t2_empty", {31'd0, inst_valid}, 32'd0);
        chk("t2_addr2", {16'd0, IM_address}, 32'd2);
        step(3);
        chk("t2_pc8", inst_pc, 32'h8);
        chk("t2_data8", inst_data, 32'hA000_0002);

        // T3: redirect in the middle of an access -> kill
        do_reset();
        fetch_en = 1'b1; inst_ready = 1'b1;
        step(8);
        chk("t3_pre_addr", {16'd0, IM_address}, 32'd2);
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        step(1);
        redirect_valid = 1'b0;
        chk("t3_kill_en", {31'd0, IM_enable}, 32'd1);
        chk("t3_kill_addr", {16'd0, IM_address}, 32'd2);
        step(1);
        chk("t3_new_addr", {16'd0, IM_address}, 32'h40);
        chk("t3_no_valid", {31'd0, inst_valid}, 32'd0);
        step(3);
        chk("t3_pc", inst_pc, 32'h100);
        chk("t3_data", inst_data, 32'hA000_0040);

        // T4: redirect on a completion cycle with a queued entry
        do_reset();
        fetch_en = 1'b1;
        step(6);
        chk("t4_pre_valid", {31'd0, inst_valid}, 32'd1);
        chk("t4_pre_stall", {31'd0, IM_stall}, 32'd0);
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        step(1);
        redirect_valid = 1'b0;
        chk("t4_flushed", {31'd0, inst_valid}, 32'd0);
        chk("t4_addr", {16'd0, IM_address}, 32'h80);
        step(3);
        chk("t4_pc", inst_pc, 32'h200);
        chk("t4_data", inst_data, 32'hA000_0080);

        // T5: asynchronous reset between clock edges
        do_reset();
        fetch_en = 1'b1; inst_ready = 1'b1;
        step(4);
        chk("t5_pre_valid", {31'd0, inst_valid}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("t5_async_en", {31'd0, IM_enable}, 32'd0);
        chk("t5_async_valid", {31'd0, inst_valid}, 32'd0);
        step(2);
        rst = 1'b0;
        step(1);
        chk("t5_restart_addr", {16'd0, IM_address}, 32'd0);
        step(3);
        chk("t5_restart_pc", inst_pc, 32'h0);

        // T6: fetch_en dropped while an access is in flight
        do_reset();
        fetch_en = 1'b1; inst_ready = 1'b1;
        step(2);
        fetch_en = 1'b0;
        step(2);
        chk("t6_en_off", {31'd0, IM_enable}, 32'd0);
        chk("t6_pushed", inst_pc, 32'h0);
        chk("t6_valid", {31'd0, inst_valid}, 32'd1);
        step(2);
        chk("t6_still_idle", {31'd0, IM_enable}, 32'd0);
        fetch_en = 1'b1;
        step(1);
        chk("t6_resume_addr", {16'd0, IM_address}, 32'd1);
        step(3);
        chk("t6_resume_pc", inst_pc, 32'h4);

        // PC wrap at the top of the address space, low bits of redirect ignored
        do_reset();
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
        step(1);
        redirect_valid = 1'b0;
        chk("wr_idle", {31'd0, IM_enable}, 32'd0);
        fetch_en = 1'b1; inst_ready = 1'b1;
        step(1);
        chk("wr_addr", {16'd0, IM_address}, 32'hFFFF);
        step(3);
        chk("wr_pc", inst_pc, 32'hFFFF_FFFC);
        chk("wr_next_addr", {16'd0, IM_address}, 32'd0);
        step(3);
        chk("wr_pc0", inst_pc, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
